// File: rtl/parity_pkg.sv
// Shared types, widths and helpers for the parity receive/check datapath.
package parity_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_SEL_WIDTH  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STOP  = 2'd2
   } rx_state_t;

   // Two data words, the select field and the parity bit.
   function automatic int frame_bits(input int dw, input int sw);
      return 2 * dw + sw + 1;
   endfunction

endpackage

// File: rtl/parity_shift_reg.sv
// MSB-first serial-in shift register with shift enable and synchronous clear.
module parity_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;

   always_comb begin
      shift_d = shift_q;
      if (clear) begin
         shift_d = '0;
      end else if (shift_en) begin
         shift_d = {shift_q[WIDTH-2:0], din};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign q = shift_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver feeding parity_core: d1, d2, sel, parity, MSB-first.
// Optional stop-bit check with framing error output: PARITY_RX_STOP_CHECK_EN.
module parity_frame_rx
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH
) (
   input  logic                  clk_ip,
   input  logic                  rst_ip,
   input  logic                  start_ip,
   input  logic                  bit_valid_ip,
   input  logic                  serial_ip,
   output logic [DATA_WIDTH-1:0] data_op_1,
   output logic [DATA_WIDTH-1:0] data_op_2,
   output logic [SEL_WIDTH-1:0]  sel_op,
   output logic                  parity_op,
   output logic                  frame_valid_op,
`ifdef PARITY_RX_STOP_CHECK_EN
   output logic                  framing_err_op,
`endif
   output logic                  busy_op
);

   localparam int FRAME_BITS = frame_bits(DATA_WIDTH, SEL_WIDTH);
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   // Without the stop check the final bit is taken straight from serial_ip,
   // so the register only needs to hold the bits before it.
`ifdef PARITY_RX_STOP_CHECK_EN
   localparam int SR_W = FRAME_BITS;
`else
   localparam int SR_W = FRAME_BITS - 1;
`endif

   rx_state_t             state_q;
   rx_state_t             state_d;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic [SR_W-1:0]       sr_q;
   logic                  sr_clear;
   logic                  sr_shift;
   logic                  load_fields;
   logic [FRAME_BITS-1:0] frame_word;

   logic [DATA_WIDTH-1:0] data1_q;
   logic [DATA_WIDTH-1:0] data1_d;
   logic [DATA_WIDTH-1:0] data2_q;
   logic [DATA_WIDTH-1:0] data2_d;
   logic [SEL_WIDTH-1:0]  sel_q;
   logic [SEL_WIDTH-1:0]  sel_d;
   logic                  parity_q;
   logic                  parity_d;
   logic                  valid_q;
   logic                  valid_d;
`ifdef PARITY_RX_STOP_CHECK_EN
   logic                  err_q;
   logic                  err_d;
`endif

   parity_shift_reg #(
      .WIDTH(SR_W)
   ) u_shift_reg (
      .clk      (clk_ip),
      .rst      (rst_ip),
      .clear    (sr_clear),
      .shift_en (sr_shift),
      .din      (serial_ip),
      .q        (sr_q)
   );

   always_ff @(posedge clk_ip or posedge rst_ip) begin
      if (rst_ip) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // A start strobe restarts reception from any state and masks a coincident bit.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (start_ip) begin
         state_d = SHIFT;
         count_d = '0;
      end else begin
         case (state_q)
            SHIFT: begin
               if (bit_valid_ip) begin
                  if (count_q == LAST_BIT) begin
                     count_d = '0;
`ifdef PARITY_RX_STOP_CHECK_EN
                     state_d = STOP;
`else
                     state_d = IDLE;
`endif
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end
               end
            end
`ifdef PARITY_RX_STOP_CHECK_EN
            STOP: begin
               if (bit_valid_ip) begin
                  state_d = IDLE;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      sr_clear = start_ip;
      sr_shift = !start_ip && (state_q == SHIFT) && bit_valid_ip;
`ifdef PARITY_RX_STOP_CHECK_EN
      load_fields = !start_ip && (state_q == STOP) && bit_valid_ip && serial_ip;
      err_d       = !start_ip && (state_q == STOP) && bit_valid_ip && !serial_ip;
      frame_word  = sr_q;
`else
      load_fields = sr_shift && (count_q == LAST_BIT);
      frame_word  = {sr_q, serial_ip};
`endif
      valid_d  = load_fields;
      data1_d  = data1_q;
      data2_d  = data2_q;
      sel_d    = sel_q;
      parity_d = parity_q;
      if (load_fields) begin
         data1_d  = frame_word[FRAME_BITS-1 -: DATA_WIDTH];
         data2_d  = frame_word[FRAME_BITS-1-DATA_WIDTH -: DATA_WIDTH];
         sel_d    = frame_word[SEL_WIDTH:1];
         parity_d = frame_word[0];
      end
   end

   always_ff @(posedge clk_ip or posedge rst_ip) begin
      if (rst_ip) begin
         data1_q  <= '0;
         data2_q  <= '0;
         sel_q    <= '0;
         parity_q <= 1'b0;
         valid_q  <= 1'b0;
`ifdef PARITY_RX_STOP_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         data1_q  <= data1_d;
         data2_q  <= data2_d;
         sel_q    <= sel_d;
         parity_q <= parity_d;
         valid_q  <= valid_d;
`ifdef PARITY_RX_STOP_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign data_op_1      = data1_q;
   assign data_op_2      = data2_q;
   assign sel_op         = sel_q;
   assign parity_op      = parity_q;
   assign frame_valid_op = valid_q;
   assign busy_op        = (state_q != IDLE);
`ifdef PARITY_RX_STOP_CHECK_EN
   assign framing_err_op = err_q;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx; covers PARITY_RX_STOP_CHECK_EN when defined.
module tb_parity_frame_rx;

   localparam int DW = 16;
   localparam int SW = 3;
   localparam int FB = 36;

   typedef struct packed {
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic [SW-1:0] sel;
      logic          par;
   } frame_t;

   logic          clk_ip       = 1'b0;
   logic          rst_ip       = 1'b1;
   logic          start_ip     = 1'b0;
   logic          bit_valid_ip = 1'b0;
   logic          serial_ip    = 1'b0;
   logic [DW-1:0] data_op_1;
   logic [DW-1:0] data_op_2;
   logic [SW-1:0] sel_op;
   logic          parity_op;
   logic          frame_valid_op;
   logic          busy_op;
`ifdef PARITY_RX_STOP_CHECK_EN
   logic          framing_err_op;
`endif

   frame_t sbQueue[$];
   frame_t holdFrame = '0;
   int     compareCount  = 0;
   int     mismatchCount = 0;

   always #5 clk_ip = ~clk_ip;

   parity_frame_rx #(
      .DATA_WIDTH(DW),
      .SEL_WIDTH (SW)
   ) dut (
      .clk_ip         (clk_ip),
      .rst_ip         (rst_ip),
      .start_ip       (start_ip),
      .bit_valid_ip   (bit_valid_ip),
      .serial_ip      (serial_ip),
      .data_op_1      (data_op_1),
      .data_op_2      (data_op_2),
      .sel_op         (sel_op),
      .parity_op      (parity_op),
      .frame_valid_op (frame_valid_op),
`ifdef PARITY_RX_STOP_CHECK_EN
      .framing_err_op (framing_err_op),
`endif
      .busy_op        (busy_op)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk_ip);
      #1;
   endtask

   task automatic checkHold();
      checkOutput("hold_data1", data_op_1, holdFrame.d1);
      checkOutput("hold_data2", data_op_2, holdFrame.d2);
      checkOutput("hold_sel", sel_op, holdFrame.sel);
      checkOutput("hold_parity", parity_op, holdFrame.par);
   endtask

   // Every valid pulse must match the oldest pending expected frame.
   always @(negedge clk_ip) begin
      frame_t e;
      if (!rst_ip && frame_valid_op) begin
         if (sbQueue.size() == 0) begin
            checkOutput("unexpected_valid", 1, 0);
         end else begin
            e = sbQueue.pop_front();
            checkOutput("sb_data1", data_op_1, e.d1);
            checkOutput("sb_data2", data_op_2, e.d2);
            checkOutput("sb_sel", sel_op, e.sel);
            checkOutput("sb_parity", parity_op, e.par);
            checkOutput("sb_parity_ok", ^{data_op_1, data_op_2, sel_op, parity_op}, 0);
         end
      end
   end

   task automatic applyStimulus(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic [SW-1:0] sel, input int maxGap,
                                input bit startWithBit, input bit stopBit);
      frame_t        f;
      logic [FB-1:0] bits;
      bit            accept;
      f.d1  = d1;
      f.d2  = d2;
      f.sel = sel;
      f.par = ^{d1, d2, sel};
      bits  = f;
`ifdef PARITY_RX_STOP_CHECK_EN
      accept = stopBit;
`else
      accept = 1'b1;
`endif
      if (accept) sbQueue.push_back(f);
      start_ip     = 1'b1;
      bit_valid_ip = startWithBit;
      serial_ip    = 1'b1;
      nextCycle();
      start_ip     = 1'b0;
      checkOutput("busy_after_start", busy_op, 1);
      for (int i = 0; i < FB; i++) begin
         bit_valid_ip = 1'b0;
         repeat ($urandom_range(0, maxGap)) begin
            nextCycle();
            checkOutput("busy_in_gap", busy_op, 1);
         end
         bit_valid_ip = 1'b1;
         serial_ip    = bits[FB-1-i];
         nextCycle();
         if (i < FB - 1) checkOutput("busy_mid", busy_op, 1);
      end
      bit_valid_ip = 1'b0;
`ifdef PARITY_RX_STOP_CHECK_EN
      checkOutput("busy_stop_wait", busy_op, 1);
      repeat ($urandom_range(0, maxGap)) nextCycle();
      bit_valid_ip = 1'b1;
      serial_ip    = stopBit;
      nextCycle();
      bit_valid_ip = 1'b0;
      checkOutput("framing_err", framing_err_op, !stopBit);
`endif
      checkOutput("valid_on_time", frame_valid_op, accept);
      checkOutput("busy_done", busy_op, 0);
      if (accept) holdFrame = f;
   endtask

   task automatic sendPartial(input int nbits);
      start_ip     = 1'b1;
      bit_valid_ip = 1'b0;
      nextCycle();
      start_ip = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         bit_valid_ip = 1'b1;
         serial_ip    = 1'($urandom_range(0, 1));
         nextCycle();
      end
      bit_valid_ip = 1'b0;
   endtask

   initial begin
      rst_ip = 1'b1;
      repeat (3) nextCycle();
      rst_ip = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bit_valid_ip = 1'b1;
         serial_ip    = 1'b1;
         nextCycle();
         checkOutput("idle_valid", frame_valid_op, 0);
      end
      bit_valid_ip = 1'b0;
      checkOutput("reset_busy", busy_op, 0);
`ifdef PARITY_RX_STOP_CHECK_EN
      checkOutput("reset_err", framing_err_op, 0);
`endif
      checkHold();

      $display("[TB] contiguous frame");
      applyStimulus(16'hA5A5, 16'h0001, 3'b101, 0, 1'b0, 1'b1);
      checkOutput("known_parity", holdFrame.par, 1);
      repeat (4) nextCycle();
      checkHold();

      $display("[TB] gapped frame");
      applyStimulus(16'hA5A5, 16'h0001, 3'b101, 5, 1'b0, 1'b1);
      repeat (2) nextCycle();
      checkHold();

      $display("[TB] restart after 20 bits");
      sendPartial(20);
      applyStimulus(16'h1234, 16'h5678, 3'b010, 2, 1'b0, 1'b1);
      nextCycle();
      checkHold();

      $display("[TB] reset after 30 bits");
      sendPartial(30);
      rst_ip = 1'b1;
      #1;
      holdFrame = '0;
      checkOutput("rst_busy", busy_op, 0);
      checkOutput("rst_valid", frame_valid_op, 0);
      checkHold();
      nextCycle();
      rst_ip = 1'b0;
      repeat (3) nextCycle();
      checkHold();
      applyStimulus(16'hBEEF, 16'hCAFE, 3'b011, 1, 1'b0, 1'b1);

      $display("[TB] back-to-back frames, coincident start and bit");
      applyStimulus(16'h8001, 16'h7FFE, 3'b111, 0, 1'b1, 1'b1);
      applyStimulus(16'hFFFF, 16'h0000, 3'b000, 0, 1'b1, 1'b1);
      nextCycle();
      checkHold();

`ifdef PARITY_RX_STOP_CHECK_EN
      $display("[TB] stop bit checks");
      applyStimulus(16'h0F0F, 16'hF0F0, 3'b110, 1, 1'b0, 1'b0);
      repeat (2) nextCycle();
      checkHold();
      applyStimulus(16'h3C3C, 16'hC3C3, 3'b001, 1, 1'b0, 1'b1);
      nextCycle();
      checkHold();
`endif

      repeat (5) nextCycle();
      checkOutput("queue_empty", sbQueue.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
